// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle 8-bit unsigned shift-add multiplier / restoring divider driving a shared ADD/SUB ALU
module muldiv_seq #(
    parameter int WIDTH = 8,
    parameter int ITERS = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic             i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_result_hi,
    output logic [WIDTH-1:0] o_result_lo,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [1:0]       o_alu_op,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_zero,
    input  logic             i_alu_lt
);
    localparam int CW = $clog2(ITERS);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic             r_op;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic             w_run;
    logic             w_carry;
    logic             w_unused_zero;
    logic [WIDTH-1:0] w_rs;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;

    // ALU is driven only while iterating; it is parked at 0 + 0 otherwise
    always_comb begin
        w_run         = r_state == S_RUN;
        w_rs          = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
        o_alu_a       = !w_run ? '0 : r_op ? w_rs : r_hi;
        o_alu_b       = !w_run ? '0 : (r_op || r_lo[0]) ? r_m : '0;
        o_alu_op      = (w_run && r_op) ? 2'b01 : 2'b00;
        w_carry       = i_alu_out < o_alu_a;
        w_hi_nxt      = r_op ? (i_alu_lt ? w_rs : i_alu_out) : {w_carry, i_alu_out[WIDTH-1:1]};
        w_lo_nxt      = r_op ? {r_lo[WIDTH-2:0], ~i_alu_lt} : {i_alu_out[0], r_lo[WIDTH-1:1]};
        w_unused_zero = i_alu_zero;
    end

    // sequencer FSM; Busy/Done are registered from the state so they lag it by one cycle
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_op        <= 1'b0;
            r_cnt       <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
            r_m         <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_div_zero  <= 1'b0;
            o_result_hi <= '0;
            o_result_lo <= '0;
        end else begin
            o_busy <= r_state == S_RUN;
            o_done <= r_state == S_DONE;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_op       <= i_op;
                        r_cnt      <= '0;
                        r_hi       <= '0;
                        r_m        <= i_op ? i_b : i_a;
                        r_lo       <= i_op ? i_a : i_b;
                        o_div_zero <= 1'b0;
                        if (i_op && i_b == '0) begin
                            o_div_zero  <= 1'b1;
                            o_result_hi <= i_a;
                            o_result_lo <= '1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_hi  <= w_hi_nxt;
                    r_lo  <= w_lo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(ITERS - 1)) begin
                        o_result_hi <= w_hi_nxt;
                        o_result_lo <= w_lo_nxt;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scoreboard bench for muldiv_seq with a behavioural ALU and arithmetic reference model
module tb_muldiv_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, dz;
    logic [7:0] hi, lo, alu_a, alu_b, alu_out;
    logic [1:0] alu_op;
    logic       alu_zero, alu_lt;
    int         checks = 0;
    int         errors = 0;
    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    assign alu_out  = (alu_op == 2'b01) ? alu_a - alu_b : alu_a + alu_b;
    assign alu_zero = alu_out == 8'd0;
    assign alu_lt   = alu_a < alu_b;

    muldiv_seq dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
        .o_busy(busy), .o_done(done), .o_div_zero(dz), .o_result_hi(hi), .o_result_lo(lo),
        .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op),
        .i_alu_out(alu_out), .i_alu_zero(alu_zero), .i_alu_lt(alu_lt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {divzero, hi, lo} from plain arithmetic
    function automatic logic [16:0] model(input logic o, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        if (!o) begin
            p = 16'(x) * 16'(y);
            return {1'b0, p};
        end
        if (y == 8'd0) return {1'b1, x, 8'hFF};
        return {1'b0, 8'(x % y), 8'(x / y)};
    endfunction

    // monitor: every Done pulse is matched against the oldest expected result
    always @(negedge clk) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%0h lo=%0h dz=%0b with nothing expected", hi, lo, dz);
            end else begin
                chk("result", {15'd0, dz, hi, lo}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic run_op(input logic o, input logic [7:0] x, input logic [7:0] y);
        int k;
        int nb;
        logic [16:0] e;
        logic z;
        e = model(o, x, y);
        z = o && (y == 8'd0);
        exp_q.push_back(e);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("divzero_at_accept", dz, e[16]);
        k = 0;
        nb = 0;
        while (!done && k < 30) begin
            if (busy) nb++;
            @(posedge clk);
            #1 k++;
        end
        chk("latency", k, z ? 1 : 9);
        chk("busy_cycles", nb, z ? 0 : 8);
        chk("alu_idle", {alu_a, alu_b, alu_op}, 0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, dz, hi, lo, alu_a, alu_b, alu_op}, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_result"}, {hi, lo}, 0);
        chk({name, "_alu"}, {alu_a, alu_b, alu_op}, 0);
    endtask

    initial begin
        logic       ro;
        logic [7:0] rx, ry;
        int         nd;
        #3 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_op(0, 8'd13, 8'd11);
        run_op(0, 8'd255, 8'd255);
        run_op(0, 8'd0, 8'd200);
        run_op(1, 8'd200, 8'd7);
        run_op(1, 8'd255, 8'd200);
        run_op(1, 8'd5, 8'd9);
        run_op(1, 8'd42, 8'd0);
        run_op(1, 8'd100, 8'd3);
        // Start held high for 20 sampled edges: exactly two operations
        exp_q.push_back(model(0, 8'd3, 8'd4));
        exp_q.push_back(model(0, 8'd3, 8'd4));
        op = 1'b0; a = 8'd3; b = 8'd4; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (i == 19) start = 1'b0;
            if (done) nd++;
        end
        chk("b2b_done_count", nd, 2);
        // abort 255*255 in its 4th RUN cycle
        op = 1'b0; a = 8'd255; b = 8'd255; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("busy_before_abort", busy, 1);
        rst_n = 1'b0;
        #1 chk_all_zero("abort");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("no_done_after_abort", nd, 0);
        run_op(0, 8'd6, 8'd7);
        for (int i = 0; i < 40; i++) begin
            ro = 1'($urandom_range(0, 1));
            rx = 8'($urandom);
            ry = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            run_op(ro, rx, ry);
        end
        repeat (3) @(posedge clk);
        #1 chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
